d_cache_requester: RTL and testbench

- Memory-stage initiator for the data cache. Accepts load/store/non-memory instructions from execute and drives the d_cache request fields (mem_access, address, mem_op, data).
- Waits for the d_cache response (valid, data) and stalls execute while busy.
- Presents one retired result per instruction to writeback under a valid/ready handshake.

---
 rtl/d_cache_requester.sv | 170 +++++++++++++++++
 tb/tb_d_cache_requester.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_cache_requester.sv
// d_cache_requester: memory-stage initiator for the data cache.
// Takes load/store/non-memory instructions from execute and issues d_cache
// requests. It waits for the d_cache response, then hands one result per
// instruction to writeback over a valid/ready handshake.
// Optional feature macro: DCACHE_REQ_TIMEOUT_EN. When it is defined, a WAIT
// that sees no response for TIMEOUT_CYCLES cycles is aborted with a
// one-cycle timeout_err pulse.
module d_cache_requester #(
  parameter int REG_ADDR_W     = 3,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic                  ex_mem_access,
  input  logic                  ex_mem_op,
  input  logic [15:0]           ex_address,
  input  logic [15:0]           ex_data,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  output logic                  stall,
  output logic                  dc_mem_access,
  output logic [15:0]           dc_address,
  output logic                  dc_mem_op,
  output logic [15:0]           dc_data,
  input  logic                  dc_valid,
  input  logic [15:0]           dc_rdata,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [15:0]           wb_data,
  output logic [REG_ADDR_W-1:0] wb_dest,
  output logic                  wb_we,
  output logic                  timeout_err
);

  // The timeout counter must be able to hold TIMEOUT_CYCLES.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (2 ** TIMEOUT_W)) begin : g_bad_cfg
    $error("d_cache_requester: TIMEOUT_CYCLES must be in 1 .. 2**TIMEOUT_W-1");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                state_q, state_d;
  logic [15:0]           addr_q, addr_d;
  logic                  op_q, op_d;
  logic [15:0]           data_q, data_d;
  logic [15:0]           wb_data_q, wb_data_d;
  logic [REG_ADDR_W-1:0] wb_dest_q, wb_dest_d;
  logic                  wb_we_q, wb_we_d;
  logic                  accept;
`ifdef DCACHE_REQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  expire;
`endif

  // Execute can hand over a new instruction when idle, or when the current
  // result retires in this same cycle.
  assign accept = ex_valid & ((state_q == S_IDLE) | ((state_q == S_RESP) & wb_ready));

  // State register plus the request and result registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values and evaluation order cannot matter.
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      op_q      <= 1'b0;
      data_q    <= '0;
      wb_data_q <= '0;
      wb_dest_q <= '0;
      wb_we_q   <= 1'b0;
`ifdef DCACHE_REQ_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      op_q      <= op_d;
      data_q    <= data_d;
      wb_data_q <= wb_data_d;
      wb_dest_q <= wb_dest_d;
      wb_we_q   <= wb_we_d;
`ifdef DCACHE_REQ_TIMEOUT_EN
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    // NOTE: every signal gets a hold/default value first, so no path through
    // the case statement leaves one unassigned and infers a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    op_d      = op_q;
    data_d    = data_q;
    wb_data_d = wb_data_q;
    wb_dest_d = wb_dest_q;
    wb_we_d   = wb_we_q;
`ifdef DCACHE_REQ_TIMEOUT_EN
    cnt_d         = cnt_q;
    timeout_err_d = 1'b0;
    expire        = ~dc_valid & (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
`endif

    case (state_q)
      S_WAIT: begin
        if (dc_valid) begin
          // A store retires with no register write and zero data.
          wb_data_d = op_q ? 16'h0000 : dc_rdata;
          wb_we_d   = ~op_q;
          state_d   = S_RESP;
`ifdef DCACHE_REQ_TIMEOUT_EN
        end else if (expire) begin
          // The in-flight request is abandoned and produces no writeback.
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + TIMEOUT_W'(1);
`endif
        end
      end
      S_RESP: begin
        if (wb_ready) state_d = S_IDLE;
      end
      default: ;
    endcase

    // Taking a new instruction overrides the IDLE fall-back from RESP, which
    // gives back-to-back issue with no bubble.
    if (accept) begin
      wb_dest_d = ex_dest;
      if (ex_mem_access) begin
        addr_d  = ex_address;
        op_d    = ex_mem_op;
        data_d  = ex_data;
        state_d = S_WAIT;
`ifdef DCACHE_REQ_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end else begin
        wb_data_d = ex_data;
        wb_we_d   = 1'b1;
        state_d   = S_RESP;
      end
    end
  end

  // Outputs decoded from the state and the registers.
  always_comb begin
    stall         = ex_valid & ~accept;
    dc_mem_access = (state_q == S_WAIT);
    wb_valid      = (state_q == S_RESP);
    dc_address    = addr_q;
    dc_mem_op     = op_q;
    dc_data       = data_q;
    wb_data       = wb_data_q;
    wb_dest       = wb_dest_q;
    wb_we         = wb_we_q;
`ifdef DCACHE_REQ_TIMEOUT_EN
    timeout_err   = timeout_err_q;
`else
    timeout_err   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_d_cache_requester.sv
// Self-checking bench for d_cache_requester. Expected writeback results are
// queued when an instruction is issued, and a monitor compares them whenever
// writeback takes a result. Request-side and handshake signals are checked
// in line with the stimulus.
module tb_d_cache_requester;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_access, ex_mem_op;
  logic [15:0] ex_address, ex_data;
  logic [2:0]  ex_dest;
  logic        stall, dc_mem_access, dc_mem_op;
  logic [15:0] dc_address, dc_data;
  logic        dc_valid;
  logic [15:0] dc_rdata;
  logic        wb_valid, wb_ready, wb_we, timeout_err;
  logic [15:0] wb_data;
  logic [2:0]  wb_dest;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  dest;
    logic        we;
  } wb_t;
  wb_t exp_q[$];

  always #5 clk = ~clk;

  d_cache_requester #(
    .REG_ADDR_W(3), .TIMEOUT_CYCLES(4), .TIMEOUT_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_mem_access(ex_mem_access), .ex_mem_op(ex_mem_op),
    .ex_address(ex_address), .ex_data(ex_data), .ex_dest(ex_dest),
    .stall(stall),
    .dc_mem_access(dc_mem_access), .dc_address(dc_address),
    .dc_mem_op(dc_mem_op), .dc_data(dc_data),
    .dc_valid(dc_valid), .dc_rdata(dc_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_dest(wb_dest), .wb_we(wb_we), .timeout_err(timeout_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_ex(input logic v, input logic ma, input logic op,
                          input logic [15:0] a, input logic [15:0] d,
                          input logic [2:0] dst);
    ex_valid      = v;
    ex_mem_access = ma;
    ex_mem_op     = op;
    ex_address    = a;
    ex_data       = d;
    ex_dest       = dst;
  endtask

  // Scoreboard monitor: every retired result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && wb_valid && wb_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wb_unexpected: got data 0x%0h dest %0d we %0b, expected none",
                 wb_data, wb_dest, wb_we);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        check("wb_data", 32'(wb_data), 32'(e.data));
        check("wb_dest", 32'(wb_dest), 32'(e.dest));
        check("wb_we",   32'(wb_we),   32'(e.we));
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive_ex(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 3'd0);
    dc_valid = 1'b0;
    dc_rdata = 16'h0;
    wb_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    sample();
    check("rst_dc_mem_access", 32'(dc_mem_access), 0);
    check("rst_wb_valid",      32'(wb_valid),      0);
    check("rst_outputs", {dc_address, dc_data}, 0);
    check("rst_wb", {13'(wb_data), wb_dest, wb_we, timeout_err, stall}, 0);

    // T1: load 0x1234 -> dest 5, response after 3 WAIT cycles.
    step();
    drive_ex(1'b1, 1'b1, 1'b0, 16'h1234, 16'h0, 3'd5);
    exp_q.push_back('{16'hBEEF, 3'd5, 1'b1});
    sample();
    check("t1_stall_idle", 32'(stall), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      ex_valid = 1'b0;
      dc_valid = (i == 2);
      dc_rdata = 16'hBEEF;
      sample();
      check("t1_dc_mem_access", 32'(dc_mem_access), 1);
      check("t1_dc_address", 32'(dc_address), 32'h1234);
      check("t1_dc_mem_op", 32'(dc_mem_op), 0);
      check("t1_wb_valid_wait", 32'(wb_valid), 0);
    end
    step();
    dc_valid = 1'b0;
    sample();
    check("t1_wb_valid", 32'(wb_valid), 1);
    check("t1_dc_dropped", 32'(dc_mem_access), 0);
    step();
    sample();
    check("t1_idle", 32'(wb_valid), 0);

    // T2: store 0x00AA to 0x0010, immediate response.
    step();
    drive_ex(1'b1, 1'b1, 1'b1, 16'h0010, 16'h00AA, 3'd3);
    exp_q.push_back('{16'h0000, 3'd3, 1'b0});
    step();
    ex_valid = 1'b0;
    dc_valid = 1'b1;
    dc_rdata = 16'h5A5A;
    sample();
    check("t2_dc_mem_op", 32'(dc_mem_op), 1);
    check("t2_dc_data", 32'(dc_data), 32'h00AA);
    check("t2_dc_address", 32'(dc_address), 32'h0010);
    step();
    dc_valid = 1'b0;
    sample();
    check("t2_wb_valid", 32'(wb_valid), 1);
    step();

    // T3: load pending with a non-memory op held on execute; no bubble.
    drive_ex(1'b1, 1'b1, 1'b0, 16'h2000, 16'h0, 3'd1);
    exp_q.push_back('{16'hD00D, 3'd1, 1'b1});
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 0) begin
        drive_ex(1'b1, 1'b0, 1'b0, 16'h0, 16'h5555, 3'd2);
        exp_q.push_back('{16'h5555, 3'd2, 1'b1});
      end
      dc_valid = (i == 2);
      dc_rdata = 16'hD00D;
      sample();
      check("t3_stall_wait", 32'(stall), 1);
    end
    step();
    dc_valid = 1'b0;
    sample();
    check("t3_stall_retire", 32'(stall), 0);
    check("t3_wb_valid_a", 32'(wb_valid), 1);
    step();
    ex_valid = 1'b0;
    sample();
    check("t3_wb_valid_b", 32'(wb_valid), 1);
    step();
    sample();
    check("t3_idle", 32'(wb_valid), 0);

    // T4: RESP held for 4 cycles with wb_ready low; dc_valid must be ignored.
    wb_ready = 1'b0;
    drive_ex(1'b1, 1'b0, 1'b0, 16'h0, 16'h0C0C, 3'd4);
    exp_q.push_back('{16'h0C0C, 3'd4, 1'b1});
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 0) begin
        drive_ex(1'b1, 1'b1, 1'b0, 16'h3000, 16'h0, 3'd6);
        exp_q.push_back('{16'h1111, 3'd6, 1'b1});
      end
      dc_valid = (i == 1 || i == 2);
      dc_rdata = 16'hFFFF;
      sample();
      check("t4_stall", 32'(stall), 1);
      check("t4_wb_hold", {wb_valid, wb_data, 5'(wb_dest), wb_we}, {1'b1, 16'h0C0C, 5'd4, 1'b1});
      check("t4_no_dc", 32'(dc_mem_access), 0);
    end
    step();
    dc_valid = 1'b0;
    wb_ready = 1'b1;
    sample();
    check("t4_stall_release", 32'(stall), 0);
    step();
    ex_valid = 1'b0;
    dc_valid = 1'b1;
    dc_rdata = 16'h1111;
    sample();
    check("t4_dc_address", 32'(dc_address), 32'h3000);
    check("t4_dc_mem_access", 32'(dc_mem_access), 1);
    step();
    dc_valid = 1'b0;
    sample();
    check("t4_wb_valid", 32'(wb_valid), 1);
    step();

    // T5: reset mid-WAIT abandons the request.
    drive_ex(1'b1, 1'b1, 1'b0, 16'h4444, 16'h0, 3'd7);
    step();
    ex_valid = 1'b0;
    sample();
    check("t5_in_wait", 32'(dc_mem_access), 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sample();
    check("t5_dc_mem_access", 32'(dc_mem_access), 0);
    check("t5_wb_valid", 32'(wb_valid), 0);
    check("t5_dc_address", 32'(dc_address), 0);
    step();
    dc_valid = 1'b1;
    dc_rdata = 16'h9999;
    step();
    dc_valid = 1'b0;
    sample();
    check("t5_late_dc_valid", {dc_mem_access, wb_valid}, 0);

    // T6: WAIT with no response for TIMEOUT_CYCLES cycles.
    step();
    drive_ex(1'b1, 1'b1, 1'b0, 16'h5000, 16'h0, 3'd1);
`ifdef DCACHE_REQ_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      step();
      ex_valid = 1'b0;
      sample();
      check("t6_wait_no_err", {dc_mem_access, timeout_err}, 2'b10);
    end
    step();
    sample();
    check("t6_timeout_pulse", {timeout_err, dc_mem_access, wb_valid}, 3'b100);
    step();
    sample();
    check("t6_pulse_end", 32'(timeout_err), 0);
    // Same again, but the response lands on the expiry cycle.
    drive_ex(1'b1, 1'b1, 1'b0, 16'h5002, 16'h0, 3'd2);
    exp_q.push_back('{16'h7777, 3'd2, 1'b1});
    for (int i = 0; i < 4; i++) begin
      step();
      ex_valid = 1'b0;
      dc_valid = (i == 3);
      dc_rdata = 16'h7777;
      sample();
      check("t6b_wait_no_err", {dc_mem_access, timeout_err}, 2'b10);
    end
    step();
    dc_valid = 1'b0;
    sample();
    check("t6b_complete", {timeout_err, wb_valid}, 2'b01);
    step();
`else
    exp_q.push_back('{16'h7777, 3'd1, 1'b1});
    for (int i = 0; i < 6; i++) begin
      step();
      ex_valid = 1'b0;
      dc_valid = (i == 5);
      dc_rdata = 16'h7777;
      sample();
      check("t6_unbounded_wait", {dc_mem_access, timeout_err}, 2'b10);
    end
    step();
    dc_valid = 1'b0;
    sample();
    check("t6_complete", {timeout_err, wb_valid}, 2'b01);
    step();
`endif

    step();
    check("sb_drain", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
